// File: rtl/booth_sequencer.sv
// booth_sequencer
//   Iterative radix-2 Booth multiplier: one Booth step per clock, followed by
//   a single conversion cycle that registers the two's-complement product
//   together with its sign-magnitude form.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high; aborts any operation in flight
//   start        begin a multiply; only looked at while ready=1
//   multiplicand signed operand M (WORD_LENGTH bits)
//   multiplier   signed operand Q (WORD_LENGTH bits)
//   ready        high in IDLE
//   busy         high in CALC and CONVERT
//   done         one-cycle pulse; product/magnitude/sign are valid
//   product      signed product (2*WORD_LENGTH bits)
//   magnitude    |product|
//   sign         1 when product is negative
module booth_sequencer #(
    parameter int WORD_LENGTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [WORD_LENGTH-1:0]   multiplicand,
    input  logic [WORD_LENGTH-1:0]   multiplier,
    output logic                     ready,
    output logic                     busy,
    output logic                     done,
    output logic [2*WORD_LENGTH-1:0] product,
    output logic [2*WORD_LENGTH-1:0] magnitude,
    output logic                     sign
);

    localparam int W  = WORD_LENGTH;
    localparam int PW = 2 * WORD_LENGTH;
    localparam int CW = $clog2(WORD_LENGTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CALC    = 2'd1,
        CONVERT = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t state, next_state;

    // A carries one guard bit so that A - M cannot overflow when
    // M = -2^(W-1).
    logic [W:0]    a;
    logic [W-1:0]  q;
    logic          q_1;
    logic [W-1:0]  m;
    logic [CW-1:0] counter;

    logic [W:0]    m_ext;
    logic [W:0]    sum;
    logic [W:0]    a_next;
    logic [W-1:0]  q_next;
    logic          last_step;
    logic [PW-1:0] prod_w;
    logic [PW-1:0] mag_w;

    assign last_step = (counter == CW'(W - 1));

    // Booth step followed by the arithmetic right shift of {A,Q,Q_1}.
    always_comb begin
        m_ext = {m[W-1], m};
        unique case ({q[0], q_1})
            2'b01:   sum = a + m_ext;
            2'b10:   sum = a - m_ext;
            default: sum = a;
        endcase
        a_next = {sum[W], sum[W:1]};
        q_next = {sum[0], q[W-1:1]};
    end

    // The guard bit is dropped here: the true product always fits in PW bits.
    always_comb begin
        prod_w = {a[W-1:0], q};
        mag_w  = prod_w[PW-1] ? (~prod_w + PW'(1)) : prod_w;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        ready      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) next_state = CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (last_step) next_state = CONVERT;
            end
            CONVERT: begin
                busy       = 1'b1;
                next_state = DONE;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a         <= '0;
            q         <= '0;
            q_1       <= 1'b0;
            m         <= '0;
            counter   <= '0;
            product   <= '0;
            magnitude <= '0;
            sign      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        m       <= multiplicand;
                        q       <= multiplier;
                        a       <= '0;
                        q_1     <= 1'b0;
                        counter <= '0;
                    end
                end
                CALC: begin
                    a       <= a_next;
                    q       <= q_next;
                    q_1     <= q[0];
                    counter <= counter + CW'(1);
                end
                CONVERT: begin
                    product   <= prod_w;
                    magnitude <= mag_w;
                    sign      <= prod_w[PW-1];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_sequencer.sv
module tb_booth_sequencer;
    localparam int W  = 16;
    localparam int PW = 2 * W;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [W-1:0]  multiplicand;
    logic [W-1:0]  multiplier;
    logic          ready;
    logic          busy;
    logic          done;
    logic [PW-1:0] product;
    logic [PW-1:0] magnitude;
    logic          sign;

    booth_sequencer #(.WORD_LENGTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .ready        (ready),
        .busy         (busy),
        .done         (done),
        .product      (product),
        .magnitude    (magnitude),
        .sign         (sign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PW-1:0] p;
        logic [PW-1:0] mag;
        logic          s;
        int            cap;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   n_done  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t make_exp(input logic [W-1:0] x, input logic [W-1:0] y, input int cap);
        exp_t   e;
        longint px, py, pr;
        px    = longint'($signed(x));
        py    = longint'($signed(y));
        pr    = px * py;
        e.p   = pr[PW-1:0];
        e.s   = (pr < 0);
        e.mag = (pr < 0) ? PW'(-pr) : PW'(pr);
        e.cap = cap;
        return e;
    endfunction

    // Edge counter; cyc read at a negedge equals the number of edges so far.
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Scoreboard checker: every done pops one expectation.
    initial begin
        logic prev_done;
        exp_t e;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_done) begin
                chk("ready_after_done", 64'(ready), 64'd1);
                chk("done_one_cycle", 64'(done), 64'd0);
            end
            prev_done = done;
            if (done) begin
                n_done++;
                if (sb.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("product", 64'(product), 64'(e.p));
                    chk("magnitude", 64'(magnitude), 64'(e.mag));
                    chk("sign", 64'(sign), 64'(e.s));
                    chk("latency", 64'(cyc - e.cap), 64'(W + 1));
                end
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (!ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready) chk("ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("done_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    // Called at a negedge; start is sampled at the next posedge.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
        wait_ready();
        multiplicand = x;
        multiplier   = y;
        start        = 1'b1;
        sb.push_back(make_exp(x, y, cyc + 1));
        @(negedge clk);
        start        = 1'b0;
        multiplicand = W'($urandom);
        multiplier   = W'($urandom);
    endtask

    initial begin
        int cap2;
        int n;
        reset        = 1'b1;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_product", 64'(product), 64'd0);
        chk("rst_magnitude", 64'(magnitude), 64'd0);
        chk("rst_sign", 64'(sign), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        issue(16'd3, 16'd5);
        chk("busy_in_calc", 64'(busy), 64'd1);
        chk("not_ready_in_calc", 64'(ready), 64'd0);
        wait_empty();
        issue(16'hFFFD, 16'd5);     wait_empty();
        issue(16'h8000, 16'h8000);  wait_empty();
        issue(16'h8000, 16'h0001);  wait_empty();
        issue(16'h0000, 16'hFFF9);  wait_empty();
        issue(16'h7FFF, 16'h7FFF);  wait_empty();
        issue(16'h1234, 16'hEDCC);  wait_empty();

        // Second start during CALC must be ignored.
        issue(16'd7, 16'd9);
        repeat (4) @(negedge clk);
        multiplicand = 16'd2;
        multiplier   = 16'd2;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
        multiplicand = 16'hABCD;
        multiplier   = 16'h5555;
        wait_empty();
        repeat (3) @(negedge clk);
        chk("single_done_count", 64'(n_done), 64'd8);

        // Reset mid-CALC aborts with no done and zeroed outputs.
        issue(16'd7, 16'd9);
        repeat (7) @(negedge clk);
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("abort_product", 64'(product), 64'd0);
        chk("abort_magnitude", 64'(magnitude), 64'd0);
        chk("abort_sign", 64'(sign), 64'd0);
        chk("abort_ready", 64'(ready), 64'd1);
        chk("abort_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        chk("abort_done_count", 64'(n_done), 64'd8);

        // Start held high: two back-to-back operations, W+3 edges apart.
        multiplicand = 16'd2;
        multiplier   = 16'hFFFC;
        start        = 1'b1;
        sb.push_back(make_exp(16'd2, 16'hFFFC, cyc + 1));
        cap2 = cyc + 1 + W + 3;
        sb.push_back(make_exp(16'd2, 16'hFFFC, cap2));
        n = 0;
        while (cyc < cap2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        wait_empty();
        repeat (3) @(negedge clk);
        chk("final_done_count", 64'(n_done), 64'd10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/booth_sequencer.md
Name: booth_sequencer

Overview:
Iterative radix-2 Booth multiplier controller with its shift/add datapath. It accepts two signed WORD_LENGTH operands through a start/ready handshake and runs one Booth step per clock. It then converts the 2*WORD_LENGTH two's-complement product to sign-magnitude form for the display/output stage. It replaces the purely combinational multiply path and owns all sequencing: load, iterate, convert and done signalling.

Parameters:
WORD_LENGTH, 16, operand width in bits; product is 2*WORD_LENGTH bits; minimum 2.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  request to begin; sampled only when ready=1.
multiplicand  input  WORD_LENGTH  signed two's-complement operand M.
multiplier  input  WORD_LENGTH  signed two's-complement operand Q.
ready  output  1  high in IDLE; the block can accept start.
busy  output  1  high in CALC and CONVERT.
done  output  1  one-cycle pulse; result outputs valid.
product  output  2*WORD_LENGTH  signed two's-complement product.
magnitude  output  2*WORD_LENGTH  absolute value of product.
sign  output  1  1 when product is negative.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high.
- Reset: state=IDLE; A, Q, Q_1, M, counter, product, magnitude, sign and done all cleared to 0; ready=1; busy=0.
- Reset asserted mid-operation aborts the operation immediately. No done pulse is produced. Outputs read 0 after reset.
- States: IDLE, CALC, CONVERT, DONE.
- IDLE: on an edge with start=1, the block captures M=multiplicand and Q=multiplier, clears A=0, Q_1=0 and counter=0, and moves to CALC. With start=0 it stays in IDLE. Previous results are held.
- CALC: each edge performs one Booth step on {Q[0],Q_1}:
  - 01: A=A+M.
  - 10: A=A-M.
  - 00 or 11: no change.
  - Then an arithmetic right shift of {A,Q,Q_1} by 1; the MSB of A is replicated.
  - A is WORD_LENGTH+1 bits internally so that M=-2^(WORD_LENGTH-1) subtraction does not overflow. product is the low 2*WORD_LENGTH bits of {A,Q}.
  - counter increments each step. After exactly WORD_LENGTH steps (counter==WORD_LENGTH-1 at the edge), the state moves to CONVERT.
- CONVERT: one edge.
  - product register loads {A,Q}.
  - If the product MSB is 1: magnitude = ~product+1 and sign=1.
  - Otherwise: magnitude = product and sign=0.
  - Next state is DONE.
- DONE: done=1 for exactly one cycle; next edge returns to IDLE unconditionally. product, magnitude and sign are held until the next CONVERT or reset.
- Latency: done is high in the cycle following edge WORD_LENGTH+1, counting the start-capture edge as edge 0. For WORD_LENGTH=16, done rises 17 edges after capture. Minimum start-to-start spacing is WORD_LENGTH+3 cycles.
- start is ignored while ready=0 (CALC, CONVERT, DONE). A start held high through DONE is accepted on the first IDLE edge.
- Operand inputs may change freely after capture without affecting the result.
- Most-negative case: (-2^(W-1))*(-2^(W-1)) = 2^(2W-2) is positive and representable; sign=0.
- Zero result gives sign=0 and magnitude=0.

Test Plan:
- Reset, then multiplicand=3, multiplier=5, start one cycle -> done pulses one cycle, 17 edges after capture; product=0x0000000F, magnitude=15, sign=0; ready returns high the next cycle.
- multiplicand=-3 (0xFFFD), multiplier=5 -> product=0xFFFFFFF1, magnitude=0x0000000F, sign=1.
- multiplicand=0x8000, multiplier=0x8000 -> product=0x40000000, sign=0. Also 0x8000*0x0001 -> product=0xFFFF8000, magnitude=0x00008000, sign=1.
- multiplicand=0, multiplier=-7 -> product=0, magnitude=0, sign=0. Also 0x7FFF*0x7FFF -> product=0x3FFF0001.
- Start 7*9, then pulse start with operands 2*2 at CALC cycle 5 and change the operand inputs -> second start ignored; result=63; exactly one done pulse.
- Start 7*9, assert reset at CALC cycle 8 for 1 cycle -> all outputs 0, ready=1, no done. Then issue 2*-4 back-to-back with a start held high -> product=0xFFFFFFF8, magnitude=8, sign=1.
